// File: rtl/mips_pkg.sv
// Shared MIPS definitions: instruction width, primary opcodes and the
// fetch-stage state encoding.
package mips_pkg;

   localparam int INSTR_W = 32;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_HOLD = 2'd2,
      S_DROP = 2'd3
   } fetch_state_e;

   function automatic logic [5:0] opcode_of(input logic [INSTR_W-1:0] instr);
      return instr[31:26];
   endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/ready bus between the fetch stage and memory.
interface if_stage_if #(
   parameter int ADDR_W = 32
);
   import mips_pkg::*;

   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic               imem_ready;
   logic [INSTR_W-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rdata
   );

endinterface

// File: rtl/if_next_pc.sv
// Combinational next-PC logic: sequential PC+4, jump/branch targets and the
// redirect decision for the instruction currently held in IF/ID.
module if_next_pc #(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] pc_i,
   input  logic [ADDR_W-1:0] if_id_pc4_i,
   input  logic [25:0]       instr_idx_i,
   input  logic              if_id_valid_i,
   input  logic              jump_i,
   input  logic              branch_i,
   input  logic              zero_i,
   output logic [ADDR_W-1:0] pc_plus4_o,
   output logic [ADDR_W-1:0] target_o,
   output logic              redirect_o
);

   logic signed [ADDR_W-1:0] br_off;
   logic        [ADDR_W-1:0] br_tgt;
   logic        [ADDR_W-1:0] j_tgt;

   assign pc_plus4_o = pc_i + ADDR_W'(4);

   // Word offset sign-extended then scaled; the add wraps modulo 2^ADDR_W.
   assign br_off = $signed({{(ADDR_W-18){instr_idx_i[15]}}, instr_idx_i[15:0], 2'b00});
   assign br_tgt = if_id_pc4_i + $unsigned(br_off);
   assign j_tgt  = {if_id_pc4_i[ADDR_W-1:28], instr_idx_i, 2'b00};

   assign target_o   = jump_i ? j_tgt : br_tgt;
   assign redirect_o = if_id_valid_i & (jump_i | (branch_i & zero_i));

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, request/ready fetch FSM with a hold
// buffer for stalls and a drop state for redirects mid-handshake, and IF/ID.
module if_stage
   import mips_pkg::*;
#(
   parameter int              ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               stall,
   input  logic               flush,
   input  logic               branch,
   input  logic               zero,
   input  logic               jump,
   if_stage_if.master         imem,
   output logic               if_id_valid,
   output logic [INSTR_W-1:0] if_id_instr,
   output logic [ADDR_W-1:0]  if_id_pc4
);

   fetch_state_e       state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [ADDR_W-1:0]  tgt_q;
   logic [INSTR_W-1:0] hold_q;
   logic               if_id_valid_q, if_id_valid_d;
   logic [INSTR_W-1:0] if_id_instr_q, if_id_instr_d;
   logic [ADDR_W-1:0]  if_id_pc4_q, if_id_pc4_d;

   logic               req;
   logic               load_new;
   logic [INSTR_W-1:0] new_instr;
   logic               hold_ld;
   logic               tgt_ld;
   logic [ADDR_W-1:0]  pc_plus4;
   logic [ADDR_W-1:0]  target;
   logic               redirect;

   if_next_pc #(.ADDR_W(ADDR_W)) u_next_pc (
      .pc_i          (pc_q),
      .if_id_pc4_i   (if_id_pc4_q),
      .instr_idx_i   (if_id_instr_q[25:0]),
      .if_id_valid_i (if_id_valid_q),
      .jump_i        (jump),
      .branch_i      (branch),
      .zero_i        (zero),
      .pc_plus4_o    (pc_plus4),
      .target_o      (target),
      .redirect_o    (redirect)
   );

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      req       = 1'b0;
      load_new  = 1'b0;
      new_instr = hold_q;
      hold_ld   = 1'b0;
      tgt_ld    = 1'b0;
      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            req = 1'b1;
            if (imem.imem_ready) begin
               if (redirect) begin
                  pc_d = target;
               end else if (!stall) begin
                  load_new  = 1'b1;
                  new_instr = imem.imem_rdata;
                  pc_d      = pc_plus4;
               end else begin
                  hold_ld = 1'b1;
                  state_d = S_HOLD;
               end
            end else if (redirect) begin
               // Address must stay put until the pending request completes.
               tgt_ld  = 1'b1;
               state_d = S_DROP;
            end
         end
         S_HOLD: begin
            if (redirect) begin
               pc_d    = target;
               state_d = S_REQ;
            end else if (!stall) begin
               load_new  = 1'b1;
               new_instr = hold_q;
               pc_d      = pc_plus4;
               state_d   = S_REQ;
            end
         end
         S_DROP: begin
            req = 1'b1;
            if (imem.imem_ready) begin
               pc_d    = tgt_q;
               state_d = S_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Squash beats stall; only valid is cleared, payload fields keep their value.
   always_comb begin
      if_id_valid_d = if_id_valid_q;
      if_id_instr_d = if_id_instr_q;
      if_id_pc4_d   = if_id_pc4_q;
      if (redirect || flush) begin
         if_id_valid_d = 1'b0;
      end else if (!stall) begin
         if (load_new) begin
            if_id_valid_d = 1'b1;
            if_id_instr_d = new_instr;
            if_id_pc4_d   = pc_plus4;
         end else begin
            if_id_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= S_IDLE;
         pc_q          <= PC_RESET;
         if_id_valid_q <= 1'b0;
         if_id_instr_q <= '0;
         if_id_pc4_q   <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         if_id_valid_q <= if_id_valid_d;
         if_id_instr_q <= if_id_instr_d;
         if_id_pc4_q   <= if_id_pc4_d;
      end
   end

   always_ff @(posedge clk) begin
      if (hold_ld) hold_q <= imem.imem_rdata;
      if (tgt_ld)  tgt_q  <= target;
   end

   assign imem.imem_req  = req;
   assign imem.imem_addr = pc_q & ~ADDR_W'(3);
   assign if_id_valid    = if_id_valid_q;
   assign if_id_instr    = if_id_instr_q;
   assign if_id_pc4      = if_id_pc4_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a small program memory and a decode model feed
// the stage; IF/ID contents and fetch addresses are checked cycle by cycle.
module tb_if_stage;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        zero_r = 1'b1;
   logic        ready_r = 1'b1;
   int          mode = 0;
   logic        jump, branch;
   logic        if_id_valid;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   if_stage_if #(.ADDR_W(32)) imem ();

   function automatic logic [31:0] tag(input logic [31:0] a);
      return {OP_ORI, 5'd0, 5'd1, a[15:0]};
   endfunction

   // mode 1: beq +3 at 0x10; mode 2: j 0x40 at 0x08; mode 3: beq -6 at 0x10.
   function automatic logic [31:0] mem_rd(input logic [31:0] a, input int m);
      if (m == 1 && a == 32'h10) return {OP_BEQ, 5'd1, 5'd2, 16'h0003};
      if (m == 2 && a == 32'h08) return {OP_J, 26'h000_0040};
      if (m == 3 && a == 32'h10) return {OP_BEQ, 5'd1, 5'd2, 16'hFFFA};
      return tag(a);
   endfunction

   assign imem.imem_ready = ready_r;
   assign imem.imem_rdata = mem_rd(imem.imem_addr, mode);
   assign jump   = (opcode_of(if_id_instr) == OP_J);
   assign branch = (opcode_of(if_id_instr) == OP_BEQ);

   if_stage #(.ADDR_W(32), .PC_RESET(32'h0000_0000)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .stall       (stall),
      .flush       (flush),
      .branch      (branch),
      .zero        (zero_r),
      .jump        (jump),
      .imem        (imem),
      .if_id_valid (if_id_valid),
      .if_id_instr (if_id_instr),
      .if_id_pc4   (if_id_pc4)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   task automatic do_reset(input int m);
      mode    = m;
      rstn    = 1'b0;
      stall   = 1'b0;
      flush   = 1'b0;
      ready_r = 1'b1;
      zero_r  = 1'b1;
      steps(2);
      rstn = 1'b1;
   endtask

   initial begin
      // Reset values and sequential fetch
      mode = 0;
      steps(2);
      chk("rst_req",   32'(imem.imem_req), 32'd0);
      chk("rst_addr",  imem.imem_addr, 32'h0);
      chk("rst_valid", 32'(if_id_valid), 32'd0);
      chk("rst_instr", if_id_instr, 32'h0);
      chk("rst_pc4",   if_id_pc4, 32'h0);
      rstn = 1'b1;
      chk("idle_req",  32'(imem.imem_req), 32'd0);
      step();
      chk("seq_req0",   32'(imem.imem_req), 32'd1);
      chk("seq_addr0",  imem.imem_addr, 32'h0);
      chk("seq_valid0", 32'(if_id_valid), 32'd0);
      step();
      chk("seq_valid1", 32'(if_id_valid), 32'd1);
      chk("seq_instr1", if_id_instr, tag(32'h0));
      chk("seq_pc4_1",  if_id_pc4, 32'h4);
      chk("seq_addr1",  imem.imem_addr, 32'h4);
      step();
      chk("seq_instr2", if_id_instr, tag(32'h4));
      chk("seq_pc4_2",  if_id_pc4, 32'h8);
      chk("seq_addr2",  imem.imem_addr, 32'h8);
      step();
      chk("seq_instr3", if_id_instr, tag(32'h8));
      chk("seq_addr3",  imem.imem_addr, 32'hC);

      // Taken beq at 0x10, offset +3
      do_reset(1);
      steps(6);
      chk("beq_instr", if_id_instr, {OP_BEQ, 5'd1, 5'd2, 16'h0003});
      chk("beq_valid", 32'(if_id_valid), 32'd1);
      chk("beq_addr",  imem.imem_addr, 32'h14);
      step();
      chk("beq_squash", 32'(if_id_valid), 32'd0);
      chk("beq_tgt",    imem.imem_addr, 32'h20);
      step();
      chk("beq_nvalid", 32'(if_id_valid), 32'd1);
      chk("beq_ninstr", if_id_instr, tag(32'h20));
      chk("beq_npc4",   if_id_pc4, 32'h24);

      // Jump at 0x08 to index 0x40
      do_reset(2);
      steps(4);
      chk("j_instr",  if_id_instr, {OP_J, 26'h000_0040});
      chk("j_addr",   imem.imem_addr, 32'hC);
      step();
      chk("j_squash", 32'(if_id_valid), 32'd0);
      chk("j_tgt",    imem.imem_addr, 32'h100);
      step();
      chk("j_nvalid", 32'(if_id_valid), 32'd1);
      chk("j_ninstr", if_id_instr, tag(32'h100));
      chk("j_npc4",   if_id_pc4, 32'h104);

      // Three-cycle stall with ready high, then a lone flush
      do_reset(0);
      steps(3);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("stall_req%0d", i),   32'(imem.imem_req), 32'd0);
         chk($sformatf("stall_addr%0d", i),  imem.imem_addr, 32'h8);
         chk($sformatf("stall_valid%0d", i), 32'(if_id_valid), 32'd1);
         chk($sformatf("stall_instr%0d", i), if_id_instr, tag(32'h4));
         chk($sformatf("stall_pc4_%0d", i),  if_id_pc4, 32'h8);
      end
      stall = 1'b0;
      step();
      chk("unstall_req",   32'(imem.imem_req), 32'd1);
      chk("unstall_addr",  imem.imem_addr, 32'hC);
      chk("unstall_instr", if_id_instr, tag(32'h8));
      chk("unstall_pc4",   if_id_pc4, 32'hC);
      step();
      chk("unstall_next",  if_id_instr, tag(32'hC));
      chk("unstall_addr2", imem.imem_addr, 32'h10);
      flush = 1'b1;
      step();
      chk("flush_valid", 32'(if_id_valid), 32'd0);
      chk("flush_instr", if_id_instr, tag(32'hC));
      chk("flush_pc4",   if_id_pc4, 32'h10);
      chk("flush_addr",  imem.imem_addr, 32'h14);
      flush = 1'b0;
      step();
      chk("flush_next",  if_id_instr, tag(32'h14));
      chk("flush_nvalid", 32'(if_id_valid), 32'd1);

      // Jump while memory is not ready: drop the pending fetch
      do_reset(2);
      steps(4);
      chk("drop_jinstr", if_id_instr, {OP_J, 26'h000_0040});
      ready_r = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("drop_req%0d", i),   32'(imem.imem_req), 32'd1);
         chk($sformatf("drop_addr%0d", i),  imem.imem_addr, 32'hC);
         chk($sformatf("drop_valid%0d", i), 32'(if_id_valid), 32'd0);
      end
      ready_r = 1'b1;
      step();
      chk("drop_tgt",    imem.imem_addr, 32'h100);
      chk("drop_valid",  32'(if_id_valid), 32'd0);
      step();
      chk("drop_ninstr", if_id_instr, tag(32'h100));
      chk("drop_nvalid", 32'(if_id_valid), 32'd1);

      // Backward beq to 0xFFFF_FFFC with flush in the same cycle, PC wraps
      do_reset(3);
      steps(6);
      chk("wrap_binstr", if_id_instr, {OP_BEQ, 5'd1, 5'd2, 16'hFFFA});
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("wrap_squash", 32'(if_id_valid), 32'd0);
      chk("wrap_tgt",    imem.imem_addr, 32'hFFFF_FFFC);
      step();
      chk("wrap_instr",  if_id_instr, tag(32'hFFFF_FFFC));
      chk("wrap_pc4",    if_id_pc4, 32'h0);
      chk("wrap_addr",   imem.imem_addr, 32'h0);
      step();
      chk("wrap_next",   if_id_instr, tag(32'h0));
      chk("wrap_npc4",   if_id_pc4, 32'h4);

      // Asynchronous reset during an outstanding request
      do_reset(0);
      steps(3);
      ready_r = 1'b0;
      step();
      chk("arst_pre_req",  32'(imem.imem_req), 32'd1);
      chk("arst_pre_addr", imem.imem_addr, 32'h8);
      rstn = 1'b0;
      #1;
      chk("arst_req",   32'(imem.imem_req), 32'd0);
      chk("arst_addr",  imem.imem_addr, 32'h0);
      chk("arst_valid", 32'(if_id_valid), 32'd0);
      chk("arst_pc4",   if_id_pc4, 32'h0);
      ready_r = 1'b1;
      step();
      chk("arst_late_valid", 32'(if_id_valid), 32'd0);
      chk("arst_late_req",   32'(imem.imem_req), 32'd0);
      rstn = 1'b1;
      step();
      chk("arst_restart_addr", imem.imem_addr, 32'h0);
      chk("arst_restart_req",  32'(imem.imem_req), 32'd1);
      step();
      chk("arst_restart_instr", if_id_instr, tag(32'h0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
